uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (start_tx/data_in/tx_busy interface) between NUM_REQ requesters.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART controller definitions: arbiter FSM states and a constant-safe clog2 helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly above ptr, else lowest set request.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               any_req
);

    // Two descending passes; the second overrides with the lowest request above ptr when one exists.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                winner  = IDW'(j);
                any_req = 1'b1;
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j] && (IDW'(j) > ptr)) begin
                winner = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ requesters, one byte per grant,
// with a watchdog on the transmitter acknowledging the start pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   active_id,
    output logic                         tx_done,
    output logic                         err_timeout
);

    localparam int IDW   = $clog2(NUM_REQ);
    localparam int CNT_W = clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT);

    arb_state_t state, state_next;
    logic [IDW-1:0]       ptr, ptr_next;
    logic [IDW-1:0]       id_next;
    logic [DATA_BITS-1:0] data_next;
    logic [NUM_REQ-1:0]   ack_next;
    logic                 start_next, done_next, err_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDW-1:0]       winner;
    logic                 any_req;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDW    (IDW)
    ) u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any_req(any_req)
    );

    // Every output is registered, so the pulses computed here appear one cycle after the decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= IDW'(NUM_REQ - 1);
            active_id   <= '0;
            tx_data     <= '0;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            tx_done     <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            active_id   <= id_next;
            tx_data     <= data_next;
            req_ack     <= ack_next;
            tx_start    <= start_next;
            tx_done     <= done_next;
            err_timeout <= err_next;
            cnt         <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        id_next    = active_id;
        data_next  = tx_data;
        ack_next   = '0;
        start_next = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        cnt_next   = cnt;
        case (state)
            // A still-busy transmitter (e.g. finishing a byte aborted by reset) blocks new grants.
            IDLE: begin
                if (any_req && !tx_busy) begin
                    ptr_next          = winner;
                    id_next           = winner;
                    data_next         = req_data[winner*DATA_BITS +: DATA_BITS];
                    ack_next[winner]  = 1'b1;
                    state_next        = ISSUE;
                end
            end
            ISSUE: begin
                start_next = 1'b1;
                cnt_next   = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt >= CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter driving a behavioural UART TX stub that captures each started byte.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int DATA_BITS    = 8;
    localparam int BUSY_TIMEOUT = 64;
    localparam int BUSY_LEN     = 30;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       timeout;
    } exp_t;

    logic                         clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ack;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_busy;
    logic [1:0]                   active_id;
    logic                         tx_done;
    logic                         err_timeout;

    logic       model_busy = 1'b0;
    int         busy_left  = 0;
    logic [7:0] captured   = 8'h00;
    logic       dead_tx    = 1'b0;
    logic       force_busy = 1'b0;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cycle      = 0;
    int   start_cycle = 0;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_BITS   (DATA_BITS),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .active_id  (active_id),
        .tx_done    (tx_done),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Transmitter stub: latches the byte on tx_start and stays busy for BUSY_LEN cycles unless dead.
    assign tx_busy = model_busy | force_busy;
    always @(posedge clk) begin
        if (tx_start && !dead_tx) begin
            model_busy <= 1'b1;
            busy_left  <= BUSY_LEN;
            captured   <= tx_data;
        end else if (busy_left != 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) model_busy <= 1'b0;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Completion monitor: every tx_done or err_timeout retires the oldest expected transfer.
    always @(negedge clk) begin
        exp_t e;
        if (tx_start) start_cycle = cycle;
        if (req_ack != '0) check_output("ack_onehot", $countones(req_ack), 1);
        if (tx_done || err_timeout) begin
            if (sb.size() == 0) begin
                check_output("unexpected_completion", {30'd0, tx_done, err_timeout}, 0);
            end else begin
                e = sb.pop_front();
                check_output("done_vs_timeout", {30'd0, tx_done, err_timeout},
                             e.timeout ? 1 : 2);
                check_output("active_id", active_id, e.id);
                if (e.timeout)
                    check_output("timeout_latency", cycle - start_cycle, BUSY_TIMEOUT);
                else
                    check_output("tx_byte", captured, e.data);
            end
        end
    end

    task automatic raise(input int idx, input logic [7:0] b);
        req_data[idx*DATA_BITS +: DATA_BITS] = b;
        req[idx] = 1'b1;
    endtask

    task automatic wait_ack(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ack[idx] && n < 500);
        if (!req_ack[idx]) check_output("ack_wait", 0, 1);
        req[idx] = 1'b0;
    endtask

    task automatic apply_stimulus(input int idx, input logic [7:0] b);
        raise(idx, b);
        wait_ack(idx);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_output("drain_pending", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ack"}, req_ack, 0);
        check_output({tag, "_start"}, tx_start, 0);
        check_output({tag, "_data"}, tx_data, 0);
        check_output({tag, "_id"}, active_id, 0);
        check_output({tag, "_done"}, tx_done, 0);
        check_output({tag, "_err"}, err_timeout, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got hang, required completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        bit flag;
        int n;
        req      = '0;
        req_data = '0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        reset_dut();

        $display("[TB] test 1: single request");
        sb.push_back('{2'd2, 8'hA5, 1'b0});
        raise(2, 8'hA5);
        @(negedge clk);
        check_output("t1_ack", req_ack, 4'b0100);
        check_output("t1_id", active_id, 2);
        check_output("t1_start_early", tx_start, 0);
        req[2] = 1'b0;
        @(negedge clk);
        check_output("t1_start", tx_start, 1);
        wait_drain(200);

        $display("[TB] test 2: all four requesting");
        reset_dut();
        sb.push_back('{2'd0, 8'h11, 1'b0});
        sb.push_back('{2'd1, 8'h22, 1'b0});
        sb.push_back('{2'd2, 8'h33, 1'b0});
        sb.push_back('{2'd3, 8'h44, 1'b0});
        sb.push_back('{2'd0, 8'h55, 1'b0});
        fork
            begin apply_stimulus(0, 8'h11); apply_stimulus(0, 8'h55); end
            apply_stimulus(1, 8'h22);
            apply_stimulus(2, 8'h33);
            apply_stimulus(3, 8'h44);
        join
        wait_drain(400);

        $display("[TB] test 3: re-asserting requester ranks last");
        sb.push_back('{2'd3, 8'h77, 1'b0});
        apply_stimulus(3, 8'h77);
        wait_drain(200);
        sb.push_back('{2'd0, 8'h01, 1'b0});
        sb.push_back('{2'd3, 8'h03, 1'b0});
        sb.push_back('{2'd0, 8'h02, 1'b0});
        fork
            begin apply_stimulus(0, 8'h01); apply_stimulus(0, 8'h02); end
            apply_stimulus(3, 8'h03);
        join
        wait_drain(300);

        $display("[TB] test 4: transmitter never goes busy");
        dead_tx = 1'b1;
        sb.push_back('{2'd1, 8'h5A, 1'b1});
        apply_stimulus(1, 8'h5A);
        wait_drain(200);
        dead_tx = 1'b0;
        sb.push_back('{2'd2, 8'h99, 1'b0});
        apply_stimulus(2, 8'h99);
        wait_drain(200);

        $display("[TB] test 5: reset during transfer");
        apply_stimulus(1, 8'hE7);
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("t5_busy_seen", tx_busy, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5");
        rst = 1'b0;
        sb.push_back('{2'd3, 8'h3C, 1'b0});
        raise(3, 8'h3C);
        flag = 1'b0;
        n = 0;
        while (tx_busy && n < 100) begin
            @(negedge clk);
            if (req_ack != '0) flag = 1'b1;
            n++;
        end
        check_output("t5_no_grant_busy", flag, 0);
        wait_ack(3);
        wait_drain(200);

        $display("[TB] test 6: busy held in idle");
        force_busy = 1'b1;
        sb.push_back('{2'd1, 8'h6D, 1'b0});
        raise(1, 8'h6D);
        flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (req_ack != '0 || tx_start) flag = 1'b1;
        end
        check_output("t6_no_grant", flag, 0);
        force_busy = 1'b0;
        @(negedge clk);
        check_output("t6_ack", req_ack, 4'b0010);
        req[1] = 1'b0;
        wait_drain(200);

        check_output("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
